// File: rtl/dmem_arbiter_if.sv
// Channel interfaces for dmem_arbiter.
//
// dmem_arbiter_req_if : one requester's command/response channel.
//   req/we/maskmode/sext/addr/wdata : command, held stable until ack
//   ack                             : combinational accept pulse
//   rvalid/rdata/err                : registered one-cycle response
//   modports: master = requester side, slave = arbiter side
//
// dmem_arbiter_mem_if : strobe bus to the single-port data memory.
//   write/read/maskmode/sext/address/write_data : arbiter -> memory
//   read_data                                   : memory -> arbiter (combinational)
//   modports: master = arbiter side, slave = memory side
interface dmem_arbiter_req_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [1:0]            maskmode;
  logic                  sext;
  logic [DATA_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ack;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;

  modport master (
    output req, we, maskmode, sext, addr, wdata,
    input  ack, rvalid, rdata, err
  );
  modport slave (
    input  req, we, maskmode, sext, addr, wdata,
    output ack, rvalid, rdata, err
  );
endinterface

interface dmem_arbiter_mem_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  write;
  logic                  read;
  logic [1:0]            maskmode;
  logic                  sext;
  logic [DATA_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] read_data;

  modport master (
    output write, read, maskmode, sext, address, write_data,
    input  read_data
  );
  modport slave (
    input  write, read, maskmode, sext, address, write_data,
    output read_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester round-robin arbiter/sequencer in front of the
// single-port data memory. One command is accepted in IDLE, the memory is
// strobed for exactly one ACCESS cycle from the latched command, and the
// granted requester gets a registered response the cycle after.
//
// Ports:
//   clk   : system clock (memory writes land on the negedge inside ACCESS)
//   rstn  : asynchronous active-low reset
//   r0    : requester 0 channel (core load/store), slave modport
//   r1    : requester 1 channel (debug/DMA), slave modport
//   mem   : data memory strobe bus, master modport
//
// NUM_REQ is fixed at 2; other values are unsupported.

// Per-requester response register: one-cycle pulse with captured data/err.
module dmem_arbiter_rsp #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_fire,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  i_err,
  output logic                  o_rvalid,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_err
);
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  // Outputs return to zero whenever this lane is not the one being answered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else if (i_fire) begin
      r_rvalid <= 1'b1;
      r_rdata  <= i_rdata;
      r_err    <= i_err;
    end else begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end
  end

  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;
  assign o_err    = r_err;
endmodule

module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2
) (
  input  logic               clk,
  input  logic               rstn,
  dmem_arbiter_req_if.slave  r0,
  dmem_arbiter_req_if.slave  r1,
  dmem_arbiter_mem_if.master mem
);
  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  typedef struct packed {
    logic                  we;
    logic [1:0]            maskmode;
    logic                  sext;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  state_t                                 r_state, w_state_nxt;
  cmd_t                                   r_cmd;
  logic                                   r_gid;
  logic                                   r_last_grant;

  logic [NUM_REQ-1:0]                     w_req;
  cmd_t [NUM_REQ-1:0]                     w_cmd;
  logic [NUM_REQ-1:0]                     w_ack;
  logic                                   w_gnt_id;
  logic                                   w_accept;
  logic                                   w_err;
  logic                                   w_access;
  logic [DATA_WIDTH-1:0]                  w_rdata_cap;
  logic [NUM_REQ-1:0]                     w_fire;
  logic [NUM_REQ-1:0]                     w_rvalid;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     w_rdata;
  logic [NUM_REQ-1:0]                     w_rerr;

  assign w_req    = {r1.req, r0.req};
  assign w_cmd[0] = {r0.we, r0.maskmode, r0.sext, r0.addr, r0.wdata};
  assign w_cmd[1] = {r1.we, r1.maskmode, r1.sext, r1.addr, r1.wdata};

  // Contention goes to whoever was not granted last; a lone request wins
  // outright. last_grant resets to 1 so r0 wins the first contention.
  always_comb begin
    if (&w_req) w_gnt_id = ~r_last_grant;
    else        w_gnt_id = w_req[1];
  end

  // FSM next-state and accept strobe
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_ack       = '0;
    case (r_state)
      S_IDLE: begin
        if (|w_req) begin
          w_accept        = 1'b1;
          w_ack[w_gnt_id] = 1'b1;
          w_state_nxt     = S_ACCESS;
        end
      end
      S_ACCESS: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  assign r0.ack = w_ack[0];
  assign r1.ack = w_ack[1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_cmd        <= '0;
      r_gid        <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cmd        <= w_cmd[w_gnt_id];
        r_gid        <= w_gnt_id;
        r_last_grant <= w_gnt_id;
      end
    end
  end

  // Alignment / legality check on the latched command
  assign w_err = ((r_cmd.maskmode == 2'b01) && r_cmd.addr[0]) ||
                 ((r_cmd.maskmode == 2'b10) && (r_cmd.addr[1:0] != 2'b00)) ||
                 (r_cmd.maskmode == 2'b11);

  assign w_access = (r_state == S_ACCESS);

  // Memory strobes come straight from r_state so an async reset drops
  // mem_write immediately, before any pending negedge write.
  always_comb begin
    mem.write      = 1'b0;
    mem.read       = 1'b0;
    mem.maskmode   = 2'b10;
    mem.sext       = 1'b0;
    mem.address    = '0;
    mem.write_data = '0;
    if (w_access) begin
      mem.write      = r_cmd.we & ~w_err;
      mem.read       = ~r_cmd.we & ~w_err;
      mem.maskmode   = r_cmd.maskmode;
      mem.sext       = r_cmd.sext;
      mem.address    = r_cmd.addr;
      mem.write_data = r_cmd.wdata;
    end
  end

  assign w_rdata_cap = (!r_cmd.we && !w_err) ? mem.read_data : '0;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp
    assign w_fire[g] = w_access && (r_gid == 1'(g));
    dmem_arbiter_rsp #(.DATA_WIDTH(DATA_WIDTH)) u_rsp (
      .clk      (clk),
      .rstn     (rstn),
      .i_fire   (w_fire[g]),
      .i_rdata  (w_rdata_cap),
      .i_err    (w_err),
      .o_rvalid (w_rvalid[g]),
      .o_rdata  (w_rdata[g]),
      .o_err    (w_rerr[g])
    );
  end

  assign r0.rvalid = w_rvalid[0];
  assign r0.rdata  = w_rdata[0];
  assign r0.err    = w_rerr[0];
  assign r1.rvalid = w_rvalid[1];
  assign r1.rdata  = w_rdata[1];
  assign r1.err    = w_rerr[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: per-requester command queues feed the DUT; a
// transaction-level reference (byte-addressed memory image, grant rule,
// fixed 2-cycle occupancy) predicts every cycle's acks, memory strobes and
// responses. A word-array memory model stands in for the real memory.
module tb_dmem_arbiter;
  localparam int DW = 32;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_req_if #(.DATA_WIDTH(DW)) r0_if ();
  dmem_arbiter_req_if #(.DATA_WIDTH(DW)) r1_if ();
  dmem_arbiter_mem_if #(.DATA_WIDTH(DW)) mem_if ();

  dmem_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .r0   (r0_if),
    .r1   (r1_if),
    .mem  (mem_if)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEADBEEF : 32'(32'h9E3779B9 * (i + 1));
  endfunction

  // ---------------- memory model (word array, negedge writes) -------------
  bit          mem_inited = 1'b0;
  logic [31:0] pmem [64];
  logic [31:0] pm_word;
  logic [7:0]  pm_b;
  logic [15:0] pm_h;

  always_comb begin
    pm_word = pmem[mem_if.address[7:2]];
    pm_b    = pm_word[{mem_if.address[1:0], 3'b000} +: 8];
    pm_h    = pm_word[{mem_if.address[1], 4'b0000} +: 16];
    case (mem_if.maskmode)
      2'b00:   mem_if.read_data = mem_if.sext ? {{24{pm_b[7]}}, pm_b} : {24'h0, pm_b};
      2'b01:   mem_if.read_data = mem_if.sext ? {{16{pm_h[15]}}, pm_h} : {16'h0, pm_h};
      default: mem_if.read_data = pm_word;
    endcase
  end

  always @(negedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 64; i++) pmem[i] <= init_word(i);
      mem_inited <= 1'b1;
    end else if (mem_if.write) begin
      case (mem_if.maskmode)
        2'b00:   pmem[mem_if.address[7:2]][{mem_if.address[1:0], 3'b000} +: 8] <= mem_if.write_data[7:0];
        2'b01:   pmem[mem_if.address[7:2]][{mem_if.address[1], 4'b0000} +: 16] <= mem_if.write_data[15:0];
        default: pmem[mem_if.address[7:2]] <= mem_if.write_data;
      endcase
    end
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        we;
    logic [1:0]  mm;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  int tests = 0;
  int fails = 0;

  logic [7:0] rmem [256];
  cmd_t q0[$], q1[$];
  bit   pres0, pres1, pop0, pop1, gaps;
  bit   m_busy;
  int   m_last;
  bit   acc_v, acc_e;  int acc_id; cmd_t acc_c; logic [31:0] acc_d;
  bit   rsp_v, rsp_e;  int rsp_id; logic [31:0] rsp_d;
  int   cyc_n, wr_cnt, rd_cnt;
  int   ack_id[$], ack_cyc[$];
  logic [31:0] r0_dlog[$], r1_dlog[$];
  bit          r0_elog[$];

  function automatic cmd_t mk(input bit we, input bit [1:0] mm, input bit sext,
                              input logic [31:0] addr, input logic [31:0] wdata);
    cmd_t c;
    c.we = we; c.mm = mm; c.sext = sext; c.addr = addr; c.wdata = wdata;
    return c;
  endfunction

  function automatic bit f_err(input cmd_t c);
    return (c.mm == 2'd1 && c.addr[0]) || (c.mm == 2'd2 && c.addr[1:0] != 2'd0) || c.mm == 2'd3;
  endfunction

  function automatic logic [31:0] ref_load(input cmd_t c);
    int n = 1 << c.mm;
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rmem[(int'(c.addr[7:0]) + i) & 255];
    if (c.sext && n == 1) v = {{24{v[7]}}, v[7:0]};
    if (c.sext && n == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic ref_store(input cmd_t c);
    int n = 1 << c.mm;
    for (int i = 0; i < n; i++) rmem[(int'(c.addr[7:0]) + i) & 255] = c.wdata[8*i +: 8];
  endtask

  function automatic logic [31:0] rword(input int a);
    return {rmem[a+3], rmem[a+2], rmem[a+1], rmem[a]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_last = 1; acc_v = 0; rsp_v = 0;
    pres0 = 0; pres1 = 0; pop0 = 0; pop1 = 0;
  endtask

  // One cycle of predictions, evaluated mid-cycle.
  task automatic check_cycle();
    int g = -1;
    cmd_t c;
    if (!m_busy) begin
      if (pres0 && pres1) g = 1 - m_last;
      else if (pres0)     g = 0;
      else if (pres1)     g = 1;
    end
    chk("r0_ack", 32'(r0_if.ack), 32'(g == 0));
    chk("r1_ack", 32'(r1_if.ack), 32'(g == 1));

    if (acc_v) begin
      chk("mem_write",      32'(mem_if.write),    32'(acc_c.we && !acc_e));
      chk("mem_read",       32'(mem_if.read),     32'(!acc_c.we && !acc_e));
      chk("mem_maskmode",   32'(mem_if.maskmode), 32'(acc_c.mm));
      chk("mem_sext",       32'(mem_if.sext),     32'(acc_c.sext));
      chk("mem_address",    mem_if.address,       acc_c.addr);
      chk("mem_write_data", mem_if.write_data,    acc_c.wdata);
    end else begin
      chk("idle_write",    32'(mem_if.write),    32'd0);
      chk("idle_read",     32'(mem_if.read),     32'd0);
      chk("idle_maskmode", 32'(mem_if.maskmode), 32'd2);
      chk("idle_address",  mem_if.address,       32'd0);
    end

    chk("r0_rvalid", 32'(r0_if.rvalid), 32'(rsp_v && rsp_id == 0));
    chk("r1_rvalid", 32'(r1_if.rvalid), 32'(rsp_v && rsp_id == 1));
    if (rsp_v) begin
      chk("r0_rdata", r0_if.rdata, (rsp_id == 0) ? rsp_d : 32'd0);
      chk("r0_err",   32'(r0_if.err), 32'(rsp_id == 0 && rsp_e));
      chk("r1_rdata", r1_if.rdata, (rsp_id == 1) ? rsp_d : 32'd0);
      chk("r1_err",   32'(r1_if.err), 32'(rsp_id == 1 && rsp_e));
    end

    if (mem_if.write) wr_cnt++;
    if (mem_if.read)  rd_cnt++;
    if (r0_if.rvalid) begin r0_dlog.push_back(r0_if.rdata); r0_elog.push_back(r0_if.err); end
    if (r1_if.rvalid) r1_dlog.push_back(r1_if.rdata);
    if (r0_if.ack && pres0) begin pop0 = 1; ack_id.push_back(0); ack_cyc.push_back(cyc_n); end
    if (r1_if.ack && pres1) begin pop1 = 1; ack_id.push_back(1); ack_cyc.push_back(cyc_n); end

    rsp_v = acc_v; rsp_id = acc_id; rsp_d = acc_d; rsp_e = acc_e;
    acc_v = (g >= 0);
    if (g >= 0) begin
      c = (g == 0) ? q0[0] : q1[0];
      acc_c = c; acc_id = g; acc_e = f_err(c);
      acc_d = (!c.we && !acc_e) ? ref_load(c) : 32'd0;
      if (c.we && !acc_e) ref_store(c);
      m_last = g;
    end
    m_busy = (g >= 0);
    cyc_n++;
  endtask

  task automatic drive();
    if (pop0) begin q0.delete(0); pres0 = 0; pop0 = 0; end
    if (pop1) begin q1.delete(0); pres1 = 0; pop1 = 0; end
    if (!pres0 && q0.size() > 0 && (!gaps || $urandom_range(3) != 0)) pres0 = 1;
    if (!pres1 && q1.size() > 0 && (!gaps || $urandom_range(3) != 0)) pres1 = 1;
    r0_if.req = pres0;
    r1_if.req = pres1;
    if (pres0) begin
      r0_if.we = q0[0].we; r0_if.maskmode = q0[0].mm; r0_if.sext = q0[0].sext;
      r0_if.addr = q0[0].addr; r0_if.wdata = q0[0].wdata;
    end
    if (pres1) begin
      r1_if.we = q1[0].we; r1_if.maskmode = q1[0].mm; r1_if.sext = q1[0].sext;
      r1_if.addr = q1[0].addr; r1_if.wdata = q1[0].wdata;
    end
  endtask

  task automatic cyc();
    drive();
    @(negedge clk);
    check_cycle();
    @(posedge clk); #1;
  endtask

  task automatic run(input int maxc);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || pres0 || pres1 || acc_v || rsp_v) && n < maxc) begin
      cyc();
      n++;
    end
    tests++;
    assert (n < maxc) else begin
      fails++;
      $error("FAIL run_timeout: observed %0d cycles, required fewer than %0d", n, maxc);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    r0_if.req = 0; r1_if.req = 0;
    q0.delete(); q1.delete();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_r0_rvalid", 32'(r0_if.rvalid), 32'd0);
    chk("rst_r1_rvalid", 32'(r1_if.rvalid), 32'd0);
    chk("rst_r0_rdata",  r0_if.rdata, 32'd0);
    chk("rst_r1_err",    32'(r1_if.err), 32'd0);
    chk("rst_mem_write", 32'(mem_if.write), 32'd0);
    chk("rst_mem_read",  32'(mem_if.read), 32'd0);
    chk("rst_mem_mm",    32'(mem_if.maskmode), 32'd2);
    chk("rst_mem_addr",  mem_if.address, 32'd0);
    chk("rst_mem_wdata", mem_if.write_data, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  initial begin
    int wr0, rd0;
    logic [31:0] w;
    r0_if.req = 0; r0_if.we = 0; r0_if.maskmode = 0; r0_if.sext = 0; r0_if.addr = 0; r0_if.wdata = 0;
    r1_if.req = 0; r1_if.we = 0; r1_if.maskmode = 0; r1_if.sext = 0; r1_if.addr = 0; r1_if.wdata = 0;
    gaps = 0; cyc_n = 0; wr_cnt = 0; rd_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      w = init_word(i);
      for (int b = 0; b < 4; b++) rmem[4*i + b] = w[8*b +: 8];
    end

    // word load of 0xDEADBEEF by r0
    do_reset();
    q0.push_back(mk(0, 2'd2, 0, 32'h10, 32'h0));
    run(20);
    chk("t1_rdata", r0_dlog[r0_dlog.size()-1], 32'hDEADBEEF);

    // r1 word store then load back
    wr0 = wr_cnt;
    q1.push_back(mk(1, 2'd2, 0, 32'h20, 32'h12345678));
    q1.push_back(mk(0, 2'd2, 0, 32'h20, 32'h0));
    run(20);
    chk("t2_rdata",  r1_dlog[r1_dlog.size()-1], 32'h12345678);
    chk("t2_wr_cyc", 32'(wr_cnt - wr0), 32'd1);

    // continuous contention from reset
    do_reset();
    ack_id.delete(); ack_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(0, 2'd2, 0, 32'(16*i), 32'h0));
      q1.push_back(mk(0, 2'd2, 0, 32'(16*i + 4), 32'h0));
    end
    run(40);
    for (int i = 0; i < 8; i++) chk("t3_order", 32'(ack_id[i]), 32'(i % 2));
    for (int i = 1; i < 8; i++) chk("t3_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd2);

    // misaligned halfword load and word store
    wr0 = wr_cnt; rd0 = rd_cnt;
    q0.push_back(mk(0, 2'd1, 0, 32'h21, 32'h0));
    q0.push_back(mk(1, 2'd2, 0, 32'h22, 32'hFFFFFFFF));
    run(20);
    chk("t4_err_a",  32'(r0_elog[r0_elog.size()-2]), 32'd1);
    chk("t4_err_b",  32'(r0_elog[r0_elog.size()-1]), 32'd1);
    chk("t4_no_wr",  32'(wr_cnt - wr0), 32'd0);
    chk("t4_no_rd",  32'(rd_cnt - rd0), 32'd0);
    chk("t4_word",   pmem[8], 32'h12345678);

    // illegal maskmode, then byte store
    q0.push_back(mk(0, 2'd3, 0, 32'h30, 32'h0));
    q0.push_back(mk(1, 2'd0, 0, 32'h30, 32'h000000AB));
    run(20);
    chk("t5_illegal_err", 32'(r0_elog[r0_elog.size()-2]), 32'd1);
    chk("t5_byte_err",    32'(r0_elog[r0_elog.size()-1]), 32'd0);
    chk("t5_byte_mem",    32'(pmem[12][7:0]), 32'hAB);
    chk("t5_word_mem",    pmem[12], rword(32'h30));

    // reset during the ACCESS cycle of a store
    do_reset();
    r1_if.req = 1; r1_if.we = 1; r1_if.maskmode = 2'd2; r1_if.sext = 0;
    r1_if.addr = 32'h40; r1_if.wdata = 32'h55AA55AA;
    @(negedge clk);
    chk("t6_ack", 32'(r1_if.ack), 32'd1);
    @(posedge clk); #1;
    r1_if.req = 0;
    chk("t6_wr_access", 32'(mem_if.write), 32'd1);
    rstn = 1'b0;
    #1;
    chk("t6_wr_drop", 32'(mem_if.write), 32'd0);
    chk("t6_mm_idle", 32'(mem_if.maskmode), 32'd2);
    chk("t6_addr_idle", mem_if.address, 32'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t6_r1_rvalid", 32'(r1_if.rvalid), 32'd0);
      chk("t6_r0_rvalid", 32'(r0_if.rvalid), 32'd0);
    end
    chk("t6_word", pmem[16], rword(32'h40));
    @(posedge clk); #1;
    model_reset();
    ack_id.delete(); ack_cyc.delete();
    q0.push_back(mk(0, 2'd2, 0, 32'h40, 32'h0));
    q1.push_back(mk(0, 2'd2, 0, 32'h44, 32'h0));
    run(20);
    chk("t6_first_grant", 32'(ack_id[0]), 32'd0);

    // randomized traffic with idle gaps
    gaps = 1;
    for (int i = 0; i < 150; i++) begin
      logic [1:0]  mm;
      logic [31:0] a;
      mm = 2'($urandom_range(3));
      a  = 32'($urandom_range(255));
      if ($urandom_range(3) != 0) begin
        if (mm == 2'd1) a[0] = 1'b0;
        if (mm == 2'd2) a[1:0] = 2'b00;
      end
      if ($urandom_range(1) != 0) q0.push_back(mk(1'($urandom_range(1)), mm, 1'($urandom_range(1)), a, $urandom));
      else                        q1.push_back(mk(1'($urandom_range(1)), mm, 1'($urandom_range(1)), a, $urandom));
    end
    run(2000);
    for (int i = 0; i < 64; i++) chk("t7_mem_image", pmem[i], rword(4*i));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
